// File: rtl/parity_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_pkg
//  Description : Shared FSM state type and error-counter constants for the
//                serial parity frame checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage
`default_nettype wire

// File: rtl/parity_frame_shift.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_shift
//  Description : LSB-first deserializing shift register with a running XOR
//                accumulator; i_first restarts the accumulator on bit 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift_en,
    input  logic              i_first,
    input  logic              i_data,
    output logic [DATA_W-1:0] o_shift,
    output logic              o_acc
);

    // Bits enter at the MSB and move down, so after DATA_W shifts the first
    // bit received sits at bit 0.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            o_shift <= '0;
            o_acc   <= 1'b0;
        end else if (i_shift_en) begin
            o_shift <= {i_data, o_shift[DATA_W-1:1]};
            o_acc   <= i_first ? i_data : (o_acc ^ i_data);
        end
    end

endmodule
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module      : parity_frame_checker
//  Description : Deserializes DATA_W data bits plus a parity bit, flags parity
//                mismatches and drops frames on an en timeout.
//                Optional: PARITY_ERR_COUNT_EN adds a saturating err_count port.
//  Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_checker
    import parity_frame_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ODD     = 0,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 en,
    output logic [DATA_W-1:0]    data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_abort,
`ifdef PARITY_ERR_COUNT_EN
    output logic [ERR_CNT_W-1:0] err_count,
`endif
    output logic                 busy
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam int                 c_GAP_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT - 1);
    localparam logic               c_ODD      = (ODD != 0);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_bit_cnt;
    logic [c_GAP_W-1:0]   r_gap;
    logic [DATA_W-1:0]    r_data_out;
    logic                 r_valid;
    logic                 r_parity_err;
    logic                 r_frame_abort;

    logic [DATA_W-1:0]    w_shift;
    logic                 w_acc;
    logic                 w_shift_en;
    logic                 w_first;
    logic                 w_timeout;
    logic                 w_mismatch;
    logic                 w_parity_done;

    assign w_first       = (r_state == IDLE);
    assign w_shift_en    = en && (r_state != PARITY);
    assign w_timeout     = (r_state != IDLE) && !en && (r_gap == c_GAP_LAST);
    assign w_mismatch    = w_acc ^ data_in ^ c_ODD;
    assign w_parity_done = (r_state == PARITY) && en;

    parity_frame_shift #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_timeout),
        .i_shift_en (w_shift_en),
        .i_first    (w_first),
        .i_data     (data_in),
        .o_shift    (w_shift),
        .o_acc      (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_bit_cnt     <= '0;
            r_gap         <= '0;
            r_data_out    <= '0;
            r_valid       <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_valid       <= 1'b0;
            r_frame_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_gap <= '0;
                    if (en) begin
                        r_state   <= DATA;
                        r_bit_cnt <= c_CNT_W'(1);
                    end
                end
                DATA, PARITY: begin
                    if (en) begin
                        r_gap <= '0;
                        if (r_state == PARITY) begin
                            r_data_out   <= w_shift;
                            r_parity_err <= w_mismatch;
                            r_valid      <= 1'b1;
                            r_state      <= IDLE;
                        end else if (r_bit_cnt == c_LAST_BIT) begin
                            r_state   <= PARITY;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end else if (w_timeout) begin
                        // Frame dropped: last good data_out/parity_err stay visible.
                        r_frame_abort <= 1'b1;
                        r_state       <= IDLE;
                        r_bit_cnt     <= '0;
                        r_gap         <= '0;
                    end else begin
                        r_gap <= r_gap + c_GAP_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_bit_cnt <= '0;
                    r_gap     <= '0;
                end
            endcase
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_parity_done && w_mismatch && (r_err_count != ERR_CNT_MAX)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`endif

    assign data_out    = r_data_out;
    assign valid       = r_valid;
    assign parity_err  = r_parity_err;
    assign frame_abort = r_frame_abort;
    assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
